// File: rtl/btb_2way.sv
// -----------------------------------------------------------------------------
// btb_2way -- two-way set-associative branch target buffer for the fetch stage.
//
// Lookup is purely combinational on registered state. The fetch PC is split
// into index = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2]. Each entry holds
// valid, tag, target and a 2-bit saturating direction counter. Each set holds
// one lru bit that names the way to replace next.
//
// A single write port carries resolved outcomes from execute. It trains hit
// entries. It allocates a new entry only on a taken miss. Writes land on the
// rising edge, so a same-cycle lookup returns the pre-update contents.
//
// Parameters:
//   NUM_SETS             number of sets (power of two, >= 2)
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous active-high reset
//   pc[31:0]             fetch PC to look up
//   btb_target_pc[31:0]  predicted target of the hit entry, 0 on miss
//   btb_pc_valid         lookup hit
//   btb_pc_predictTaken  counter[1] of the hit entry, 0 on miss
//   update_en            resolved control-transfer outcome valid this cycle
//   update_pc[31:0]      PC of the resolved instruction
//   update_target[31:0]  resolved target address
//   update_taken         resolved direction
//   hit_count[31:0]        (BTB_STATS_EN only) cycles with btb_pc_valid=1
//   mispredict_count[31:0] (BTB_STATS_EN only) mispredicted resolved updates
//
// Optional feature: define BTB_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module btb_2way #(
   parameter int NUM_SETS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] btb_target_pc,
   output logic        btb_pc_valid,
   output logic        btb_pc_predictTaken,
   input  logic        update_en,
   input  logic [31:0] update_pc,
   input  logic [31:0] update_target,
`ifdef BTB_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] mispredict_count,
`endif
   input  logic        update_taken
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 30 - IDX_W;

   // State arrays, indexed [way][set].
   logic             valid_q  [2][NUM_SETS];
   logic [1:0]       ctr_q    [2][NUM_SETS];
   logic             lru_q    [NUM_SETS];
   logic [TAG_W-1:0] tag_q    [2][NUM_SETS];
   logic [31:0]      target_q [2][NUM_SETS];

   // The byte-offset bits never take part in indexing or tag compare.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc[1:0], update_pc[1:0]};

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [1:0]       rd_match;
   logic             rd_way;

   assign rd_idx = pc[IDX_W+1:2];
   assign rd_tag = pc[31:IDX_W+2];

   always_comb begin
      for (int w = 0; w < 2; w++) begin
         rd_match[w] = valid_q[w][rd_idx] && (tag_q[w][rd_idx] == rd_tag);
      end
   end

   // At most one way matches, so way 1 is selected only when it is the match.
   assign rd_way = rd_match[1];

   assign btb_pc_valid        = |rd_match;
   assign btb_target_pc       = btb_pc_valid ? target_q[rd_way][rd_idx] : 32'h0;
   assign btb_pc_predictTaken = btb_pc_valid ? ctr_q[rd_way][rd_idx][1] : 1'b0;

   // ---------------------------------------------------------------- update
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic [1:0]       up_match;
   logic             up_hit;
   logic             up_hit_way;
   logic             alloc_way;
   logic             wr_way;
   logic             do_write;
   logic [1:0]       ctr_nxt;

   assign up_idx = update_pc[IDX_W+1:2];
   assign up_tag = update_pc[31:IDX_W+2];

   always_comb begin
      for (int w = 0; w < 2; w++) begin
         up_match[w] = valid_q[w][up_idx] && (tag_q[w][up_idx] == up_tag);
      end
   end

   assign up_hit     = |up_match;
   assign up_hit_way = up_match[1];

   // Victim choice on a miss: first invalid way (way 0 first), else the lru way.
   always_comb begin
      // NOTE: every path assigns alloc_way, starting from a default, so no latch is inferred.
      alloc_way = lru_q[up_idx];
      if (!valid_q[0][up_idx]) begin
         alloc_way = 1'b0;
      end else if (!valid_q[1][up_idx]) begin
         alloc_way = 1'b1;
      end
   end

   assign wr_way   = up_hit ? up_hit_way : alloc_way;
   // A not-taken miss leaves the table untouched.
   assign do_write = update_en && (up_hit || update_taken);

   always_comb begin
      ctr_nxt = 2'b10;                 // weakly taken on allocation
      if (up_hit) begin
         if (update_taken) begin
            ctr_nxt = (ctr_q[wr_way][up_idx] == 2'b11) ? 2'b11
                                                       : ctr_q[wr_way][up_idx] + 2'd1;
         end else begin
            ctr_nxt = (ctr_q[wr_way][up_idx] == 2'b00) ? 2'b00
                                                       : ctr_q[wr_way][up_idx] - 2'd1;
         end
      end
   end

   // Control state: valid, counters and lru bits are cleared by reset.
   // An update presented while rst is high is dropped because reset wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            lru_q[s] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               valid_q[w][s] <= 1'b0;
               ctr_q[w][s]   <= 2'b00;
            end
         end
      end else if (do_write) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         valid_q[wr_way][up_idx] <= 1'b1;
         ctr_q[wr_way][up_idx]   <= ctr_nxt;
         lru_q[up_idx]           <= ~wr_way;
      end
   end

   // Payload arrays. A write that coincides with reset is harmless: reset
   // clears every valid bit, so the payload is never observed.
   // NOTE: tag and target arrays are not reset; valid gates every use of them.
   always_ff @(posedge clk) begin
      if (do_write && update_taken) begin
         tag_q[wr_way][up_idx]    <= up_tag;
         target_q[wr_way][up_idx] <= update_target;
      end
   end

`ifdef BTB_STATS_EN
   // ------------------------------------------------------------ statistics
   logic up_pred_taken;
   logic mispredict;

   // Predicted direction for update_pc: counter MSB on a hit, not-taken on a miss.
   assign up_pred_taken = up_hit && ctr_q[up_hit_way][up_idx][1];
   assign mispredict    = update_en &&
                          ((up_pred_taken != update_taken) ||
                           (update_taken && up_hit &&
                            (target_q[up_hit_way][up_idx] != update_target)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count        <= 32'h0;
         mispredict_count <= 32'h0;
      end else begin
         if (btb_pc_valid) begin
            hit_count <= hit_count + 32'd1;
         end
         if (mispredict) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end
`endif

endmodule
